pipeline_opcode_tracker: RTL and testbench

//  Producer side of the per-stage opcode interface consumed by the control decoder.

---
 rtl/pipeline_opcode_tracker.sv | 274 +++++++++++++++++++++++++++
 tb/tb_pipeline_opcode_tracker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_opcode_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_opcode_tracker
//  Purpose  : Producer side of the per-stage opcode interface for the control
//             decoder. Carries opcode / funct / register fields through the
//             ID, EX, MEM and WB stage registers. Inserts a bubble on a
//             load-use hazard, squashes the instruction entering ID on a
//             redirect, and drains the pipe when a HALT reaches ID.
//  Ports    : clk, rst              - clock, async active-high reset
//             Instr                 - instruction from fetch (every cycle)
//             Redirect              - squash the instruction entering ID
//             OpcodeID/EX/MEM/WB    - opcode held in each stage
//             FunctionCode          - funct field of the WB instruction
//             Op1ID, Op2ID          - register fields in ID
//             Op1EX, Op1WB          - destination field in EX / WB
//             PCWrite, IFIDWrite    - fetch-side write enables (comb)
//             Stall                 - load-use bubble this cycle (comb)
//             Halted                - HALT retired, sticky until reset
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_opcode_tracker #(
    parameter int         INSTR_W = 16,
    parameter logic [3:0] NOP_OP  = 4'b0000,
    parameter logic [3:0] HALT_OP = 4'b1111,
    parameter logic [3:0] LOAD_OP = 4'b0110,
    parameter logic [3:0] LBU_OP  = 4'b0100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] Instr,
    input  logic               Redirect,
    output logic [3:0]         OpcodeID,
    output logic [3:0]         OpcodeEX,
    output logic [3:0]         OpcodeMEM,
    output logic [3:0]         OpcodeWB,
    output logic [3:0]         FunctionCode,
    output logic [3:0]         Op1ID,
    output logic [3:0]         Op2ID,
    output logic [3:0]         Op1EX,
    output logic [3:0]         Op1WB,
    output logic               PCWrite,
    output logic               IFIDWrite,
    output logic               Stall,
    output logic               Halted
);

    // FSM encoding
    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    // ID register source select
    localparam logic [1:0] ID_NOP   = 2'd0;
    localparam logic [1:0] ID_LOAD  = 2'd1;
    localparam logic [1:0] ID_HOLD  = 2'd2;

    // Number of DRAIN cycles between the halt entering EX and reaching WB
    localparam logic [1:0] C_HALT_IN_WB = 2'd2;

    // ------------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------------
    // ID keeps all four fields: {opcode, op1, op2, funct}
    logic [15:0] r_id;
    logic [3:0]  r_ex_op,  r_ex_op1,  r_ex_fn;
    logic [3:0]  r_mem_op, r_mem_op1, r_mem_fn;
    logic [3:0]  r_wb_op,  r_wb_op1,  r_wb_fn;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [1:0]  r_drain_cnt;
    logic        r_halted;

    // Control from the output process
    logic        w_stall;
    logic        w_pcwrite;
    logic        w_ifidwrite;
    logic [1:0]  w_id_sel;
    logic        w_ex_bubble;
    logic        w_clear_all;
    logic        w_cnt_inc;

    // Decoded fields
    logic [15:0] w_fetch;
    logic [3:0]  w_id_op, w_id_op1, w_id_op2;
    logic        w_load_use;
    logic        w_halt_in_id;
    logic        w_halt_retire;

    // Only the four architected fields are kept; for wider instructions the
    // funct nibble stays at the bottom and the rest is taken from the top.
    assign w_fetch  = {Instr[INSTR_W-1 -: 12], Instr[3:0]};

    assign w_id_op  = r_id[15:12];
    assign w_id_op1 = r_id[11:8];
    assign w_id_op2 = r_id[7:4];

    // Raw hazard condition; only acted on in RUN. Register 0 is not special.
    assign w_load_use = ((r_ex_op == LOAD_OP) || (r_ex_op == LBU_OP)) &&
                        ((r_ex_op1 == w_id_op1) || (r_ex_op1 == w_id_op2));

    assign w_halt_in_id  = (w_id_op == HALT_OP);
    assign w_halt_retire = (r_wb_op == HALT_OP) && (r_drain_cnt == C_HALT_IN_WB);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RUN: begin
                // A stalled HALT waits in ID until the bubble clears
                if (w_halt_in_id && !w_load_use) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_halt_retire) begin
                    w_next_state = S_HALTED;
                end
            end
            S_HALTED: begin
                w_next_state = S_HALTED;
            end
            default: begin
                w_next_state = S_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output / datapath control
    // ------------------------------------------------------------------------
    always_comb begin
        w_stall     = 1'b0;
        w_pcwrite   = 1'b0;
        w_ifidwrite = 1'b0;
        w_id_sel    = ID_NOP;
        w_ex_bubble = 1'b0;
        w_clear_all = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_load_use) begin
                    // Stall wins over Redirect: ID holds, EX takes a bubble
                    w_stall     = 1'b1;
                    w_id_sel    = ID_HOLD;
                    w_ex_bubble = 1'b1;
                end else if (w_halt_in_id) begin
                    // Halt moves on to EX, nothing new is fetched behind it
                    w_id_sel    = ID_NOP;
                end else begin
                    w_pcwrite   = 1'b1;
                    w_ifidwrite = 1'b1;
                    w_id_sel    = Redirect ? ID_NOP : ID_LOAD;
                end
            end
            S_DRAIN: begin
                w_id_sel  = ID_NOP;
                w_cnt_inc = 1'b1;
            end
            S_HALTED: begin
                w_clear_all = 1'b1;
            end
            default: begin
                w_clear_all = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id      <= {NOP_OP, 12'h000};
            r_ex_op   <= NOP_OP;
            r_ex_op1  <= 4'h0;
            r_ex_fn   <= 4'h0;
            r_mem_op  <= NOP_OP;
            r_mem_op1 <= 4'h0;
            r_mem_fn  <= 4'h0;
            r_wb_op   <= NOP_OP;
            r_wb_op1  <= 4'h0;
            r_wb_fn   <= 4'h0;
        end else if (w_clear_all) begin
            r_id      <= {NOP_OP, 12'h000};
            r_ex_op   <= NOP_OP;
            r_ex_op1  <= 4'h0;
            r_ex_fn   <= 4'h0;
            r_mem_op  <= NOP_OP;
            r_mem_op1 <= 4'h0;
            r_mem_fn  <= 4'h0;
            r_wb_op   <= NOP_OP;
            r_wb_op1  <= 4'h0;
            r_wb_fn   <= 4'h0;
        end else begin
            case (w_id_sel)
                ID_LOAD: r_id <= w_fetch;
                ID_HOLD: r_id <= r_id;
                default: r_id <= {NOP_OP, 12'h000};
            endcase

            if (w_ex_bubble) begin
                r_ex_op  <= NOP_OP;
                r_ex_op1 <= 4'h0;
                r_ex_fn  <= 4'h0;
            end else begin
                r_ex_op  <= w_id_op;
                r_ex_op1 <= w_id_op1;
                r_ex_fn  <= r_id[3:0];
            end

            r_mem_op  <= r_ex_op;
            r_mem_op1 <= r_ex_op1;
            r_mem_fn  <= r_ex_fn;

            r_wb_op   <= r_mem_op;
            r_wb_op1  <= r_mem_op1;
            r_wb_fn   <= r_mem_fn;
        end
    end

    // ------------------------------------------------------------------------
    // Halt progress counter and sticky halted flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drain_cnt <= 2'd0;
        end else if (!w_cnt_inc) begin
            r_drain_cnt <= 2'd0;
        end else if (r_drain_cnt != 2'd3) begin
            r_drain_cnt <= r_drain_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if ((r_state == S_DRAIN) && w_halt_retire) begin
            r_halted <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign OpcodeID     = w_id_op;
    assign Op1ID        = w_id_op1;
    assign Op2ID        = w_id_op2;
    assign OpcodeEX     = r_ex_op;
    assign Op1EX        = r_ex_op1;
    assign OpcodeMEM    = r_mem_op;
    assign OpcodeWB     = r_wb_op;
    assign Op1WB        = r_wb_op1;
    assign FunctionCode = r_wb_fn;
    assign PCWrite      = w_pcwrite;
    assign IFIDWrite    = w_ifidwrite;
    assign Stall        = w_stall;
    assign Halted       = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_opcode_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_opcode_tracker
//  Purpose  : Directed self-checking bench for pipeline_opcode_tracker.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_opcode_tracker;

    logic        clk;
    logic        rst;
    logic [15:0] Instr;
    logic        Redirect;
    logic [3:0]  OpcodeID, OpcodeEX, OpcodeMEM, OpcodeWB, FunctionCode;
    logic [3:0]  Op1ID, Op2ID, Op1EX, Op1WB;
    logic        PCWrite, IFIDWrite, Stall, Halted;

    int checks   = 0;
    int failures = 0;

    pipeline_opcode_tracker #(
        .INSTR_W (16),
        .NOP_OP  (4'b0000),
        .HALT_OP (4'b1111),
        .LOAD_OP (4'b0110),
        .LBU_OP  (4'b0100)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .Instr        (Instr),
        .Redirect     (Redirect),
        .OpcodeID     (OpcodeID),
        .OpcodeEX     (OpcodeEX),
        .OpcodeMEM    (OpcodeMEM),
        .OpcodeWB     (OpcodeWB),
        .FunctionCode (FunctionCode),
        .Op1ID        (Op1ID),
        .Op2ID        (Op2ID),
        .Op1EX        (Op1EX),
        .Op1WB        (Op1WB),
        .PCWrite      (PCWrite),
        .IFIDWrite    (IFIDWrite),
        .Stall        (Stall),
        .Halted       (Halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock edge, then settle away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        Instr    = 16'h1123;
        Redirect = 1'b0;
        #2;

        // ---------------- 1. reset state and plain flow ----------------
        chk("rst_opid",  {12'h0, OpcodeID},  16'h0);
        chk("rst_opex",  {12'h0, OpcodeEX},  16'h0);
        chk("rst_opmem", {12'h0, OpcodeMEM}, 16'h0);
        chk("rst_opwb",  {12'h0, OpcodeWB},  16'h0);
        chk("rst_halt",  {15'h0, Halted},    16'h0);
        chk("rst_pcw",   {15'h0, PCWrite},   16'h1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("t1_opid1", {12'h0, OpcodeID}, 16'h1);
        chk("t1_pcw1",  {15'h0, PCWrite},  16'h1);
        tick();
        tick();
        chk("t1_pcw3",  {15'h0, PCWrite},  16'h1);
        chk("t1_wb_pre", {12'h0, OpcodeWB}, 16'h0);
        tick();
        chk("t1_opwb4", {12'h0, OpcodeWB},     16'h1);
        chk("t1_fn4",   {12'h0, FunctionCode}, 16'h3);
        chk("t1_op1wb", {12'h0, Op1WB},        16'h1);

        // ---------------- 2. load-use stall ----------------
        Instr = 16'h6200;
        tick();
        Instr = 16'h1320;
        tick();
        chk("t2_opex_ld", {12'h0, OpcodeEX}, 16'h6);
        chk("t2_stall",   {15'h0, Stall},    16'h1);
        chk("t2_pcw",     {15'h0, PCWrite},  16'h0);
        chk("t2_ifidw",   {15'h0, IFIDWrite}, 16'h0);
        Instr = 16'h1111;
        tick();
        chk("t2_opex_bub", {12'h0, OpcodeEX},  16'h0);
        chk("t2_id_hold",  {12'h0, Op1ID},     16'h3);
        chk("t2_opmem_ld", {12'h0, OpcodeMEM}, 16'h6);
        chk("t2_stall_off", {15'h0, Stall},    16'h0);
        chk("t2_pcw_on",   {15'h0, PCWrite},   16'h1);
        tick();
        chk("t2_add_ex",  {12'h0, OpcodeEX}, 16'h1);
        chk("t2_add_op1", {12'h0, Op1EX},    16'h3);
        chk("t2_id_next", {12'h0, Op2ID},    16'h1);
        chk("t2_wb_ld",   {12'h0, OpcodeWB}, 16'h6);
        chk("t2_wb_op1",  {12'h0, Op1WB},    16'h2);

        // ---------------- 3. redirect, no hazard ----------------
        Instr    = 16'h1456;
        Redirect = 1'b1;
        #1;
        chk("t3_pcw",   {15'h0, PCWrite}, 16'h1);
        chk("t3_stall", {15'h0, Stall},   16'h0);
        tick();
        Redirect = 1'b0;
        chk("t3_id_nop", {12'h0, OpcodeID}, 16'h0);
        chk("t3_ex_op",  {12'h0, OpcodeEX}, 16'h1);
        chk("t3_ex_op1", {12'h0, Op1EX},    16'h1);

        // ---------------- 4. redirect during stall ----------------
        Instr = 16'h6500;
        tick();
        Instr = 16'h1155;
        tick();
        Redirect = 1'b1;
        Instr    = 16'h1777;
        #1;
        chk("t4_stall", {15'h0, Stall},   16'h1);
        chk("t4_pcw",   {15'h0, PCWrite}, 16'h0);
        tick();
        Redirect = 1'b0;
        chk("t4_id_hold", {12'h0, OpcodeID}, 16'h1);
        chk("t4_id_op2",  {12'h0, Op2ID},    16'h5);
        chk("t4_ex_bub",  {12'h0, OpcodeEX}, 16'h0);
        tick();
        chk("t4_ex_add", {12'h0, Op1EX},    16'h1);
        chk("t4_id_new", {12'h0, Op1ID},    16'h7);

        // ---------------- 5. halt and drain ----------------
        Instr = 16'hF000;
        tick();
        Instr = 16'h1111;
        #1;
        chk("t5_pcw_halt_id", {15'h0, PCWrite}, 16'h0);
        tick();
        chk("t5_ex_halt", {12'h0, OpcodeEX}, 16'hF);
        chk("t5_id_nop",  {12'h0, OpcodeID}, 16'h0);
        chk("t5_pcw_d1",  {15'h0, PCWrite},  16'h0);
        Redirect = 1'b1;
        tick();
        Redirect = 1'b0;
        chk("t5_mem_halt", {12'h0, OpcodeMEM}, 16'hF);
        chk("t5_ex_clean", {12'h0, OpcodeEX},  16'h0);
        tick();
        chk("t5_wb_halt",  {12'h0, OpcodeWB},  16'hF);
        chk("t5_not_yet",  {15'h0, Halted},    16'h0);
        chk("t5_ex_clean2", {12'h0, OpcodeEX}, 16'h0);
        tick();
        chk("t5_halted",   {15'h0, Halted},    16'h1);
        chk("t5_wb_nop",   {12'h0, OpcodeWB},  16'h0);
        chk("t5_pcw_h",    {15'h0, PCWrite},   16'h0);
        chk("t5_ifidw_h",  {15'h0, IFIDWrite}, 16'h0);
        tick();
        chk("t5_sticky",   {15'h0, Halted},    16'h1);
        chk("t5_id_h",     {12'h0, OpcodeID},  16'h0);

        // ---------------- 6. reset during drain ----------------
        rst = 1'b1;
        #1;
        chk("t6_rst_halted", {15'h0, Halted}, 16'h0);
        @(negedge clk);
        rst   = 1'b0;
        Instr = 16'hF000;
        tick();
        chk("t6_id_halt", {12'h0, OpcodeID}, 16'hF);
        Instr = 16'h1111;
        tick();
        tick();
        chk("t6_mem_halt", {12'h0, OpcodeMEM}, 16'hF);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_opid",  {12'h0, OpcodeID},  16'h0);
        chk("t6_opex",  {12'h0, OpcodeEX},  16'h0);
        chk("t6_opmem", {12'h0, OpcodeMEM}, 16'h0);
        chk("t6_opwb",  {12'h0, OpcodeWB},  16'h0);
        chk("t6_halt0", {15'h0, Halted},    16'h0);
        @(negedge clk);
        rst   = 1'b0;
        Instr = 16'h1234;
        #1;
        chk("t6_pcw_run", {15'h0, PCWrite}, 16'h1);
        tick();
        chk("t6_resume", {12'h0, OpcodeID}, 16'h1);
        chk("t6_op2",    {12'h0, Op2ID},    16'h3);

        // Second full halt after reset: drain timing must start fresh
        Instr = 16'hF000;
        tick();
        Instr = 16'h1111;
        tick();
        tick();
        tick();
        chk("t6_wb_halt2", {12'h0, OpcodeWB}, 16'hF);
        chk("t6_not_yet2", {15'h0, Halted},   16'h0);
        tick();
        chk("t6_halted2",  {15'h0, Halted},   16'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
